fb_pixel_writer: RTL

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

---
 rtl/fb_pixel_writer_pkg.sv | 19 +
 rtl/fb_addr_pipe.sv | 69 ++++++
 rtl/fb_pixel_writer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fb_pixel_writer_pkg.sv
// rtl/fb_pixel_writer_pkg.sv - shared defaults, FSM state type and address-width helper
package fb_pixel_writer_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 180;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CLEAR_DONE
  } fb_state_e;

  function automatic int fb_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int FB_ADDR_W_DEF = fb_addr_w(FB_WIDTH_DEF, FB_HEIGHT_DEF);

endpackage

// File: rtl/fb_addr_pipe.sv
// rtl/fb_addr_pipe.sv - two-stage clip and linear-address pipeline for rasterizer pixels
module fb_addr_pipe
  import fb_pixel_writer_pkg::*;
#(
  parameter int COORD_WIDTH = 32,
  parameter int FB_WIDTH    = FB_WIDTH_DEF,
  parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter int COLOR_WIDTH = 8,
  parameter int ADDR_W      = FB_ADDR_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush,
  input  logic [COORD_WIDTH-1:0] pixel_x,
  input  logic [COORD_WIDTH-1:0] pixel_y,
  input  logic                   pixel_valid,
  input  logic [COLOR_WIDTH-1:0] pixel_color,
  output logic                   clip,
  output logic [ADDR_W-1:0]      addr,
  output logic [COLOR_WIDTH-1:0] data,
  output logic                   en
);

  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

  logic                   x_ok, y_ok, in_bounds;
  logic                   s1_valid, s1_inb;
  logic [XW-1:0]          s1_x;
  logic [YW-1:0]          s1_y;
  logic [COLOR_WIDTH-1:0] s1_color;

  // A clear sign bit lets the upper bound be an unsigned compare.
  assign x_ok      = !pixel_x[COORD_WIDTH-1] && (pixel_x < COORD_WIDTH'(FB_WIDTH));
  assign y_ok      = !pixel_y[COORD_WIDTH-1] && (pixel_y < COORD_WIDTH'(FB_HEIGHT));
  assign in_bounds = x_ok && y_ok;
  assign clip      = pixel_valid && !in_bounds;

  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      s1_valid <= 1'b0;
      s1_inb   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_inb   <= in_bounds;
      s1_x     <= pixel_x[XW-1:0];
      s1_y     <= pixel_y[YW-1:0];
      s1_color <= pixel_color;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      en   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      en <= s1_valid && s1_inb && !flush;
      if (s1_valid && s1_inb) begin
        addr <= ADDR_W'(s1_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(s1_x);
        data <= s1_color;
      end
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - framebuffer write port: pixel pipeline, clear sweep, stats (FB_PIXEL_STATS_EN)
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int                     COORD_WIDTH = 32,
  parameter int                     FB_WIDTH    = FB_WIDTH_DEF,
  parameter int                     FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter int                     COLOR_WIDTH = 8,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
  localparam int                    ADDR_W      = fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [COORD_WIDTH-1:0] pixel_x,
  input  logic [COORD_WIDTH-1:0] pixel_y,
  input  logic                   pixel_valid,
  input  logic [COLOR_WIDTH-1:0] pixel_color,
  input  logic                   clear_start,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [COLOR_WIDTH-1:0] wr_data,
  output logic                   wr_en,
  output logic                   clearing,
  output logic                   clear_done,
  output logic [31:0]            pixels_written,
  output logic [31:0]            pixels_clipped
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  fb_state_e              state, state_next;
  logic [ADDR_W-1:0]      clr_cnt;
  logic                   accept_clear, pipe_valid;
  logic                   pipe_clip, pipe_en;
  logic [ADDR_W-1:0]      pipe_addr;
  logic [COLOR_WIDTH-1:0] pipe_data;

  assign accept_clear = (state == IDLE) && clear_start;
  // Pixels are only accepted in IDLE, and a simultaneous clear request wins.
  assign pipe_valid   = (state == IDLE) && pixel_valid && !clear_start;

  fb_addr_pipe #(
    .COORD_WIDTH (COORD_WIDTH),
    .FB_WIDTH    (FB_WIDTH),
    .FB_HEIGHT   (FB_HEIGHT),
    .COLOR_WIDTH (COLOR_WIDTH),
    .ADDR_W      (ADDR_W)
  ) u_addr_pipe (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush       (accept_clear),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pipe_valid),
    .pixel_color (pixel_color),
    .clip        (pipe_clip),
    .addr        (pipe_addr),
    .data        (pipe_data),
    .en          (pipe_en)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept_clear) begin
        clr_cnt <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    clearing   = 1'b0;
    clear_done = 1'b0;
    wr_en      = pipe_en;
    wr_addr    = pipe_addr;
    wr_data    = pipe_data;
    case (state)
      IDLE: begin
        if (clear_start) state_next = CLEAR;
      end
      CLEAR: begin
        clearing = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = clr_cnt;
        wr_data  = CLEAR_COLOR;
        if (clr_cnt == LAST_ADDR) state_next = CLEAR_DONE;
      end
      CLEAR_DONE: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FB_PIXEL_STATS_EN
  logic [31:0] written_q, clipped_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || accept_clear) begin
      written_q <= '0;
      clipped_q <= '0;
    end else begin
      if (pipe_en && (written_q != '1)) written_q <= written_q + 1'b1;
      if (pipe_clip && (clipped_q != '1)) clipped_q <= clipped_q + 1'b1;
    end
  end

  assign pixels_written = written_q;
  assign pixels_clipped = clipped_q;
`else
  logic stats_unused;
  assign stats_unused   = pipe_clip;
  assign pixels_written = '0;
  assign pixels_clipped = '0;
`endif

endmodule
